// File: rtl/inv_clarke_park_seq.sv
// Inverse Park then inverse Clarke on (d,q,sin,cos) -> (a,b,c) using one shared multiplier.
// Latency: out_valid 5 edges after accept; outputs are held while out_ready is low; in_ready is low while busy.
module inv_clarke_park_seq #(
  parameter int N = 10,
  parameter int F = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] d,
  input  logic [N-1:0] q,
  input  logic [N-1:0] sin,
  input  logic [N-1:0] cos,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] a,
  output logic [N-1:0] b,
  output logic [N-1:0] c,
  output logic         sat
);

  localparam int AW = 2*N + 2;
  localparam int MW = N + F;
  localparam int PW = 2*N + F;
  localparam int W  = PW + 1;

  // round(sqrt(3)/2 * 2^F) in pure integer arithmetic
  localparam longint SQ = (64'sd8660254 * (64'sd1 <<< F) + 64'sd5000000) / 64'sd10000000;
  localparam logic signed [MW-1:0] SQRT3_2 = MW'(SQ);

  localparam logic signed [W-1:0] MAXV = {{(W-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [W-1:0] MINV = {{(W-N+1){1'b1}}, {(N-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, M0, M1, M2, M3, M4, DONE} state_t;

  state_t state, state_nxt;

  logic signed [N-1:0]  d_r, q_r, sin_r, cos_r;
  logic signed [N-1:0]  alpha, beta;
  logic                 sat_acc;
  logic signed [AW-1:0] acc, acc_nxt, acc_sh, prod_t;
  logic signed [MW-1:0] mul_a;
  logic signed [N-1:0]  mul_b;
  logic signed [PW-1:0] prod;
  logic signed [W-1:0]  acc_w, p_w, h_w, bsum, csum, b_w, c_w;

  function automatic logic ovf_n(input logic signed [W-1:0] x);
    return (x > MAXV) || (x < MINV);
  endfunction

  function automatic logic [N-1:0] sat_n(input logic signed [W-1:0] x);
    if (x > MAXV)
      return MAXV[N-1:0];
    else if (x < MINV)
      return MINV[N-1:0];
    else
      return x[N-1:0];
  endfunction

  // state register
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = M0;
      M0:      state_nxt = M1;
      M1:      state_nxt = M2;
      M2:      state_nxt = M3;
      M3:      state_nxt = M4;
      M4:      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // handshake outputs decode purely from state
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // shared multiplier operand select
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      M0: begin mul_a = {{F{d_r[N-1]}}, d_r}; mul_b = cos_r; end
      M1: begin mul_a = {{F{q_r[N-1]}}, q_r}; mul_b = sin_r; end
      M2: begin mul_a = {{F{d_r[N-1]}}, d_r}; mul_b = sin_r; end
      M3: begin mul_a = {{F{q_r[N-1]}}, q_r}; mul_b = cos_r; end
      M4: begin mul_a = SQRT3_2;              mul_b = beta;  end
      default: begin mul_a = '0; mul_b = '0; end
    endcase
  end

  assign prod   = mul_a * mul_b;
  assign prod_t = prod[AW-1:0];

  always_comb begin
    acc_nxt = prod_t;
    case (state)
      M1:      acc_nxt = acc - prod_t;
      M3:      acc_nxt = acc + prod_t;
      default: acc_nxt = prod_t;
    endcase
    acc_sh = acc_nxt >>> F;
    acc_w  = {{(W-AW){acc_sh[AW-1]}}, acc_sh};
  end

  // phase b/c: (+-sqrt3/2*beta - alpha/2), kept at 2F fractional bits until the final shift
  always_comb begin
    p_w  = {prod[PW-1], prod};
    h_w  = {{(W-N){alpha[N-1]}}, alpha} <<< (F-1);
    bsum = p_w - h_w;
    csum = -p_w - h_w;
    b_w  = bsum >>> F;
    c_w  = csum >>> F;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_r     <= '0;
      q_r     <= '0;
      sin_r   <= '0;
      cos_r   <= '0;
      acc     <= '0;
      alpha   <= '0;
      beta    <= '0;
      sat_acc <= 1'b0;
      a       <= '0;
      b       <= '0;
      c       <= '0;
      sat     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            d_r     <= d;
            q_r     <= q;
            sin_r   <= sin;
            cos_r   <= cos;
            sat_acc <= 1'b0;
          end
        end
        M0, M2: acc <= acc_nxt;
        M1: begin
          acc     <= acc_nxt;
          alpha   <= sat_n(acc_w);
          sat_acc <= sat_acc | ovf_n(acc_w);
        end
        M3: begin
          acc     <= acc_nxt;
          beta    <= sat_n(acc_w);
          sat_acc <= sat_acc | ovf_n(acc_w);
        end
        M4: begin
          a   <= alpha;
          b   <= sat_n(b_w);
          c   <= sat_n(c_w);
          sat <= sat_acc | ovf_n(b_w) | ovf_n(c_w);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_clarke_park_seq.sv
// Randomized and directed checks of inv_clarke_park_seq against an integer reference model.
module tb_inv_clarke_park_seq;
  localparam int N = 10;
  localparam int F = 9;
  localparam int ONE = 1 << F;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] d, q, sin, cos;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] a, b, c;
  logic         sat;

  int nvec = 0;
  int nerr = 0;

  inv_clarke_park_seq #(.N(N), .F(F)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .d(d), .q(q), .sin(sin), .cos(cos),
    .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .c(c), .sat(sat)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int floor_div(input int x, input int m);
    if (x >= 0) return x / m;
    return -((-x + m - 1) / m);
  endfunction

  function automatic bit out_of_range(input int x);
    return (x > 511) || (x < -512);
  endfunction

  function automatic int clampv(input int x);
    if (x > 511) return 511;
    if (x < -512) return -512;
    return x;
  endfunction

  // alpha = d cos - q sin, beta = d sin + q cos; a = alpha, b/c = -alpha/2 +- sqrt3/2 beta
  function automatic void model(input int vd, input int vq, input int vs, input int vc,
                                output int ea, output int eb, output int ec, output bit es);
    int ar, br, al, be, p, h, bb, cc;
    ar = floor_div(vd * vc - vq * vs, ONE);
    br = floor_div(vd * vs + vq * vc, ONE);
    al = clampv(ar);
    be = clampv(br);
    p  = 443 * be;
    h  = al * (ONE / 2);
    bb = floor_div(p - h, ONE);
    cc = floor_div(-p - h, ONE);
    ea = al;
    eb = clampv(bb);
    ec = clampv(cc);
    es = out_of_range(ar) | out_of_range(br) | out_of_range(bb) | out_of_range(cc);
  endfunction

  function automatic int rnd_val();
    case ($urandom_range(0, 7))
      0: return -512;
      1: return 511;
      2: return 0;
      default: return int'($urandom_range(0, 1023)) - 512;
    endcase
  endfunction

  // Entered just after a negedge; leaves just after a negedge with the result drained.
  task automatic run_txn(input int vd, input int vq, input int vs, input int vc,
                         input int hold, input string tag);
    int ea, eb, ec, lat;
    bit es;
    logic [N-1:0] xa, xb, xc;
    model(vd, vq, vs, vc, ea, eb, ec, es);
    xa = ea[N-1:0];
    xb = eb[N-1:0];
    xc = ec[N-1:0];
    nvec++;
    if (in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL %s in_ready before accept: got %b want 1", tag, in_ready);
    end
    d = vd[N-1:0]; q = vq[N-1:0]; sin = vs[N-1:0]; cos = vc[N-1:0];
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (out_valid !== 1'b1 && lat < 20);
    nvec++;
    if (lat != 5) begin
      nerr++;
      $display("FAIL %s latency: got %0d edges want 5", tag, lat);
    end
    nvec++;
    if (a !== xa) begin nerr++; $display("FAIL %s a: got %0d want %0d", tag, $signed(a), ea); end
    nvec++;
    if (b !== xb) begin nerr++; $display("FAIL %s b: got %0d want %0d", tag, $signed(b), eb); end
    nvec++;
    if (c !== xc) begin nerr++; $display("FAIL %s c: got %0d want %0d", tag, $signed(c), ec); end
    nvec++;
    if (sat !== es) begin nerr++; $display("FAIL %s sat: got %b want %b", tag, sat, es); end
    for (int i = 0; i < hold; i++) begin
      in_valid = ~in_valid;
      d = $urandom_range(0, 1023); q = $urandom_range(0, 1023);
      sin = $urandom_range(0, 1023); cos = $urandom_range(0, 1023);
      @(negedge clk);
      nvec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || a !== xa || b !== xb || c !== xc || sat !== es) begin
        nerr++;
        $display("FAIL %s hold cycle %0d: got ov=%b ir=%b a=%0d b=%0d c=%0d sat=%b want ov=1 ir=0 a=%0d b=%0d c=%0d sat=%b",
                 tag, i, out_valid, in_ready, $signed(a), $signed(b), $signed(c), sat, ea, eb, ec, es);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    nvec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL %s after handshake: got ov=%b ir=%b want ov=0 ir=1", tag, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    d = '0; q = '0; sin = '0; cos = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    nvec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || a !== '0 || b !== '0 || c !== '0 || sat !== 1'b0) begin
      nerr++;
      $display("FAIL reset state: got ir=%b ov=%b a=%0d b=%0d c=%0d sat=%b want ir=1 ov=0 a=b=c=0 sat=0",
               in_ready, out_valid, $signed(a), $signed(b), $signed(c), sat);
    end
  endtask

  task automatic test_directed();
    run_txn(256, 0, 0, 511, 0, "dir_alpha_pos");
    run_txn(0, 256, 511, 0, 0, "dir_alpha_neg");
    run_txn(256, 0, 511, 0, 0, "dir_beta_pos");
    run_txn(511, 511, 511, -512, 0, "dir_sat");
  endtask

  task automatic test_backpressure();
    run_txn(300, -200, 181, 480, 10, "bp_held");
    run_txn(-123, 77, -400, 290, 0, "bp_next");
  endtask

  task automatic test_reset_midop();
    int seen;
    d = 10'd400; q = 10'd100; sin = 10'd200; cos = 10'd300;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    nvec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || a !== '0 || b !== '0 || c !== '0 || sat !== 1'b0) begin
      nerr++;
      $display("FAIL midop reset: got ir=%b ov=%b a=%0d b=%0d c=%0d sat=%b want ir=1 ov=0 a=b=c=0 sat=0",
               in_ready, out_valid, $signed(a), $signed(b), $signed(c), sat);
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    nvec++;
    if (seen != 0) begin
      nerr++;
      $display("FAIL midop stale out_valid: got %0d pulses want 0", seen);
    end
    run_txn(-300, 250, 100, -450, 0, "post_reset");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 150; i++)
      run_txn(rnd_val(), rnd_val(), rnd_val(), rnd_val(), int'($urandom_range(0, 3)), "random");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
